// File: rtl/repl_pkg.sv
// Shared types and constants for the cache replacement controller.
package repl_pkg;

   // Way count the per-set state struct is laid out for; the controller's
   // NUM_WAY must match it.
   localparam int REPL_NUM_WAY = 4;
   localparam int REPL_PTR_W   = $clog2(REPL_NUM_WAY);

   // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   typedef enum logic [1:0] {
      PLRU   = 2'd0,
      FIFO   = 2'd1,
      RANDOM = 2'd2
   } repl_mode_e;

   typedef enum logic {
      ST_INIT,
      ST_READY
   } repl_fsm_e;

   typedef struct packed {
      logic [REPL_NUM_WAY-2:0] tree;
      logic [REPL_PTR_W-1:0]   fifo_ptr;
   } repl_state_t;

   // One Galois LFSR step.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
   endfunction

endpackage

// File: rtl/repl_tree_pick.sv
// Combinational victim selection: PLRU tree walk or external candidate,
// then invalid-first / lock-skipping priority.
module repl_tree_pick #(
   parameter int NUM_WAY = 4
) (
   input  logic [NUM_WAY-2:0]         tree_i,
   input  logic                       use_tree_i,
   input  logic [$clog2(NUM_WAY)-1:0] cand_i,
   input  logic [NUM_WAY-1:0]         valid_i,
   input  logic [NUM_WAY-1:0]         lock_i,
   output logic [NUM_WAY-1:0]         way_o,
   output logic                       none_o
);
   localparam int PW = $clog2(NUM_WAY);

   logic [PW-1:0] plru;
   logic [PW-1:0] cand;
   logic [PW-1:0] idx;
   logic [PW-1:0] sel;
   logic          found;
   logic          b;
   int            node;

   // Walk the tree root to leaf, then apply the victim priority order.
   always_comb begin
      plru  = '0;
      node  = 0;
      b     = 1'b0;
      for (int l = PW - 1; l >= 0; l--) begin
         b = 1'b0;
         for (int n = 0; n < NUM_WAY - 1; n++) begin
            if (n == node) b = tree_i[n];
         end
         plru[l] = b;
         node    = 2 * node + 1 + int'(b);
      end
      cand   = use_tree_i ? plru : cand_i;
      found  = 1'b0;
      sel    = '0;
      idx    = '0;
      way_o  = '0;
      none_o = 1'b1;
      // An empty, unlocked slot always wins over the policy.
      for (int i = 0; i < NUM_WAY; i++) begin
         if (!found && !valid_i[i] && !lock_i[i]) begin
            found = 1'b1;
            sel   = PW'(i);
         end
      end
      // Candidate first, then scan upward with wrap (PW-bit add wraps).
      for (int i = 0; i < NUM_WAY; i++) begin
         idx = cand + PW'(i);
         if (!found && !lock_i[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      if (found) begin
         way_o[sel] = 1'b1;
         none_o     = 1'b0;
      end
   end

endmodule

// File: rtl/repl_ctrl.sv
// Stateful multi-set replacement controller: per-set PLRU tree and FIFO
// pointer, LFSR for random mode, clear-sweep FSM, registered victim response.
module repl_ctrl
   import repl_pkg::*;
#(
   parameter int          NUM_WAY   = REPL_NUM_WAY,
   parameter int          NUM_SET   = 64,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic [1:0]                 mode_i,
   input  logic [NUM_WAY-1:0]         lock_mask_i,
   input  logic                       vic_req_i,
   input  logic [$clog2(NUM_SET)-1:0] vic_set_i,
   input  logic [NUM_WAY-1:0]         vic_valid_vec_i,
   output logic                       vic_ready_o,
   output logic                       vic_valid_o,
   output logic [NUM_WAY-1:0]         vic_way_o,
   output logic                       vic_none_o,
   input  logic                       upd_valid_i,
   input  logic [$clog2(NUM_SET)-1:0] upd_set_i,
   input  logic [NUM_WAY-1:0]         upd_way_vec_i,
   input  logic                       upd_fill_i,
   output logic                       busy_o
);
   localparam int PW = $clog2(NUM_WAY);
   localparam int SW = $clog2(NUM_SET);

   repl_state_t   state_q [NUM_SET];
   repl_state_t   state_d [NUM_SET];
   repl_fsm_e     fsm_q, fsm_d;
   logic [SW-1:0] init_cnt_q, init_cnt_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic          vic_valid_q, vic_valid_d;
   logic [NUM_WAY-1:0] vic_way_q, vic_way_d;
   logic          vic_none_q, vic_none_d;

   repl_state_t   cur_st;
   repl_mode_e    mode;
   logic          use_tree;
   logic [PW-1:0] cand;
   logic [NUM_WAY-1:0] pick_way;
   logic          pick_none;
   logic          accept;
   logic [PW-1:0] upd_way;
   logic [NUM_WAY-2:0] upd_tree;
   int            node;

   assign busy_o      = (fsm_q == ST_INIT);
   assign vic_ready_o = (fsm_q == ST_READY);
   assign accept      = vic_req_i && vic_ready_o;
   assign vic_valid_o = vic_valid_q;
   assign vic_way_o   = vic_way_q;
   assign vic_none_o  = vic_none_q;

   // Policy candidate from the requested set's pre-update state.
   always_comb begin
      cur_st   = state_q[vic_set_i];
      mode     = repl_mode_e'(mode_i);
      use_tree = !(mode == FIFO || mode == RANDOM);
      cand     = (mode == RANDOM) ? lfsr_q[PW-1:0] : cur_st.fifo_ptr;
   end

   repl_tree_pick #(.NUM_WAY(NUM_WAY)) u_pick (
      .tree_i     (cur_st.tree),
      .use_tree_i (use_tree),
      .cand_i     (cand),
      .valid_i    (vic_valid_vec_i),
      .lock_i     (lock_mask_i),
      .way_o      (pick_way),
      .none_o     (pick_none)
   );

   // Accessed way (lowest set bit) and its tree with the path pointing away.
   always_comb begin
      upd_way = '0;
      for (int i = NUM_WAY - 1; i >= 0; i--) begin
         if (upd_way_vec_i[i]) upd_way = PW'(i);
      end
      upd_tree = state_q[upd_set_i].tree;
      node     = 0;
      for (int l = PW - 1; l >= 0; l--) begin
         for (int n = 0; n < NUM_WAY - 1; n++) begin
            if (n == node) upd_tree[n] = ~upd_way[l];
         end
         node = 2 * node + 1 + int'(upd_way[l]);
      end
   end

   // State array next value: sweep clear in INIT, access updates in READY.
   always_comb begin
      state_d = state_q;
      if (fsm_q == ST_INIT) begin
         state_d[init_cnt_q] = '0;
      end else if (upd_valid_i && |upd_way_vec_i) begin
         state_d[upd_set_i].tree = upd_tree;
         if (upd_fill_i) state_d[upd_set_i].fifo_ptr = upd_way + PW'(1);
      end
   end

   // FSM, LFSR and response register next values.
   always_comb begin
      fsm_d       = fsm_q;
      init_cnt_d  = init_cnt_q;
      lfsr_d      = lfsr_q;
      vic_valid_d = accept;
      vic_way_d   = accept ? pick_way : '0;
      vic_none_d  = accept ? pick_none : 1'b0;
      if (fsm_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + SW'(1);
         if (init_cnt_q == SW'(NUM_SET - 1)) fsm_d = ST_READY;
      end
      if (accept) lfsr_d = lfsr_step(lfsr_q);
      if (flush_i) begin
         fsm_d      = ST_INIT;
         init_cnt_d = '0;
      end
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q       <= ST_INIT;
         init_cnt_q  <= '0;
         lfsr_q      <= LFSR_SEED;
         vic_valid_q <= 1'b0;
         vic_way_q   <= '0;
         vic_none_q  <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         init_cnt_q  <= init_cnt_d;
         lfsr_q      <= lfsr_d;
         vic_valid_q <= vic_valid_d;
         vic_way_q   <= vic_way_d;
         vic_none_q  <= vic_none_d;
      end
   end

   // State array; the INIT sweep clears it, so it needs no reset.
   always_ff @(posedge clk_i) begin
      state_q <= state_d;
   end

endmodule

// File: tb/tb_repl_ctrl.sv
// Directed bench for repl_ctrl (NUM_WAY=4, NUM_SET=64).
module tb_repl_ctrl;
   logic       clk = 1'b0;
   logic       rst, flush, vic_req, upd_valid, upd_fill;
   logic [1:0] mode;
   logic [3:0] lock_mask, vic_valid_vec, upd_way_vec;
   logic [5:0] vic_set, upd_set;
   logic       vic_ready_o, vic_valid_o, vic_none_o, busy_o;
   logic [3:0] vic_way_o;
   int         passes = 0;
   int         fails  = 0;
   int         total  = 0;

   repl_ctrl #(.NUM_WAY(4), .NUM_SET(64), .LFSR_SEED(16'hACE1)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .mode_i(mode),
      .lock_mask_i(lock_mask), .vic_req_i(vic_req), .vic_set_i(vic_set),
      .vic_valid_vec_i(vic_valid_vec), .vic_ready_o(vic_ready_o),
      .vic_valid_o(vic_valid_o), .vic_way_o(vic_way_o), .vic_none_o(vic_none_o),
      .upd_valid_i(upd_valid), .upd_set_i(upd_set), .upd_way_vec_i(upd_way_vec),
      .upd_fill_i(upd_fill), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_upd(input logic [5:0] s, input logic [3:0] wv, input logic fill);
      upd_valid = 1'b1; upd_set = s; upd_way_vec = wv; upd_fill = fill;
      @(posedge clk); #1;
      upd_valid = 1'b0; upd_fill = 1'b0; upd_way_vec = 4'b0;
   endtask

   task automatic do_req(input string tag, input logic [5:0] s, input logic [3:0] vv,
                         input logic [3:0] lk, input logic [3:0] exp_way, input logic exp_none);
      vic_req = 1'b1; vic_set = s; vic_valid_vec = vv; lock_mask = lk;
      @(posedge clk); #1;
      vic_req = 1'b0; vic_valid_vec = 4'hF; lock_mask = 4'h0;
      chk({tag, ".vld"},  32'(vic_valid_o), 32'd1);
      chk({tag, ".way"},  32'(vic_way_o),   32'(exp_way));
      chk({tag, ".none"}, 32'(vic_none_o),  32'(exp_none));
   endtask

   // Counts busy cycles; optionally fires a fill update to set 0 mid-sweep.
   task automatic busy_count(input string tag, input bit drop_upd);
      int n;
      n = 0;
      chk({tag, ".rdy0"}, 32'(vic_ready_o), 32'd0);
      while (busy_o === 1'b1 && n < 200) begin
         if (drop_upd && n == 5) begin
            upd_valid = 1'b1; upd_set = 6'd0; upd_way_vec = 4'b0001; upd_fill = 1'b1;
         end
         n++;
         @(posedge clk); #1;
         upd_valid = 1'b0; upd_fill = 1'b0; upd_way_vec = 4'b0;
      end
      chk({tag, ".cycles"}, 32'(n), 32'd64);
      chk({tag, ".rdy1"}, 32'(vic_ready_o), 32'd1);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; vic_req = 1'b0; upd_valid = 1'b0; upd_fill = 1'b0;
      mode = 2'd0; lock_mask = 4'h0; vic_valid_vec = 4'hF; upd_way_vec = 4'h0;
      vic_set = 6'd0; upd_set = 6'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.vld",  32'(vic_valid_o), 32'd0);
      chk("rst.way",  32'(vic_way_o),   32'd0);
      chk("rst.none", 32'(vic_none_o),  32'd0);
      chk("rst.rdy",  32'(vic_ready_o), 32'd0);
      chk("rst.busy", 32'(busy_o),      32'd1);
      rst = 1'b0;
      busy_count("init", 1'b0);

      // Random mode: LFSR ACE1 -> cand 1; next E270 -> cand 0, locked -> way1.
      mode = 2'd2;
      do_req("rnd0", 6'd0, 4'hF, 4'h0, 4'b0010, 1'b0);
      chk("rnd0.pulse", 32'(vic_valid_o), 32'd1);
      do_req("rnd1", 6'd0, 4'hF, 4'b0001, 4'b0010, 1'b0);
      @(posedge clk); #1;
      chk("idle.vld", 32'(vic_valid_o), 32'd0);
      chk("idle.way", 32'(vic_way_o),   32'd0);

      // PLRU: touch way0 then way2 in set 5 -> LRU is way1.
      mode = 2'd0;
      do_upd(6'd5, 4'b0001, 1'b0);
      do_upd(6'd5, 4'b0100, 1'b0);
      do_req("plru",      6'd5, 4'hF,    4'h0,    4'b0010, 1'b0);
      do_req("inv",       6'd5, 4'b1011, 4'h0,    4'b0100, 1'b0);
      do_req("inv_lock",  6'd5, 4'b1011, 4'b0100, 4'b0010, 1'b0);
      do_req("cand_lock", 6'd5, 4'hF,    4'b0010, 4'b0100, 1'b0);
      do_req("all_lock",  6'd5, 4'hF,    4'hF,    4'b0000, 1'b1);
      mode = 2'd3;
      do_req("mode3",     6'd5, 4'hF,    4'h0,    4'b0010, 1'b0);

      // FIFO: fills to ways 0,1 -> ptr 2; non-fill update leaves ptr alone.
      mode = 2'd1;
      do_upd(6'd3, 4'b0001, 1'b1);
      do_upd(6'd3, 4'b0010, 1'b1);
      do_req("fifo3", 6'd3, 4'hF, 4'h0, 4'b0100, 1'b0);
      do_req("fifo4", 6'd4, 4'hF, 4'h0, 4'b0001, 1'b0);
      do_upd(6'd3, 4'b1000, 1'b0);
      do_req("fifo3_nofill", 6'd3, 4'hF, 4'h0, 4'b0100, 1'b0);
      do_upd(6'd4, 4'b0110, 1'b1);
      do_req("fifo4_multi", 6'd4, 4'hF, 4'h0, 4'b0100, 1'b0);
      do_upd(6'd6, 4'b0000, 1'b1);
      do_req("fifo6_zero", 6'd6, 4'hF, 4'h0, 4'b0001, 1'b0);

      // Same-cycle update and request: pre-update answer, then updated one.
      mode = 2'd0;
      upd_valid = 1'b1; upd_set = 6'd7; upd_way_vec = 4'b0010;
      do_req("same_cyc", 6'd7, 4'hF, 4'h0, 4'b0001, 1'b0);
      upd_valid = 1'b0; upd_way_vec = 4'b0;
      do_req("after_upd", 6'd7, 4'hF, 4'h0, 4'b0100, 1'b0);

      // Flush with a request in the same cycle: response from pre-flush state.
      flush = 1'b1;
      do_req("flush_req", 6'd5, 4'hF, 4'h0, 4'b0010, 1'b0);
      flush = 1'b0;
      busy_count("flush", 1'b1);
      mode = 2'd1;
      do_req("post_set0", 6'd0, 4'hF, 4'h0, 4'b0001, 1'b0);
      do_req("post_set3", 6'd3, 4'hF, 4'h0, 4'b0001, 1'b0);
      mode = 2'd0;
      do_req("post_set5", 6'd5, 4'hF, 4'h0, 4'b0001, 1'b0);
      do_req("post_set7", 6'd7, 4'hF, 4'h0, 4'b0001, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/repl_ctrl.md
# repl_ctrl

Stateful, multi-set, multi-policy cache replacement controller. Successor to the combinational tree-PLRU helper. Holds per-set replacement state internally and selects victims with tree-PLRU, FIFO or LFSR-random policy. Honours per-way valid and lock masks. Sits beside the cache tag array: the cache controller issues victim requests on misses and access updates on hits and fills.

## Interface
- NUM_WAY, 4: associativity; power of two, ≥2.
- NUM_SET, 64: number of sets; power of two, ≥2.
- LFSR_SEED, 16'hACE1: random-policy LFSR reset value; must be nonzero.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  restart the state-clear sweep.
- mode_i  in  2  policy: 0 = PLRU, 1 = FIFO, 2 = RANDOM, 3 = PLRU.
- lock_mask_i  in  NUM_WAY  locked ways are never selected as victim.
- vic_req_i  in  1  victim request.
- vic_set_i  in  $clog2(NUM_SET)  set index of the request.
- vic_valid_vec_i  in  NUM_WAY  valid bits of the requested set.
- vic_ready_o  out  1  request accepted when vic_req_i && vic_ready_o.
- vic_valid_o  out  1  response strobe.
- vic_way_o  out  NUM_WAY  one-hot victim.
- vic_none_o  out  1  all ways locked; no victim available.
- upd_valid_i  in  1  access update.
- upd_set_i  in  $clog2(NUM_SET)  set index of the update.
- upd_way_vec_i  in  NUM_WAY  accessed way, one-hot.
- upd_fill_i  in  1  update is a line fill; advances the FIFO pointer.
- busy_o  out  1  clear sweep in progress.

## Operation
- Per-set state, held in a flop array:
  - tree[NUM_WAY-2:0], heap-indexed: node 0 is the root; node n has children 2n+1 and 2n+2.
  - fifo_ptr[$clog2(NUM_WAY)-1:0].
- Both state fields are maintained in every mode. A mode change takes effect on the next accepted request.
- Tree bit meaning: 0 means the victim lies in the lower half, 1 means the upper half. An update sets every node on the path of the accessed way to point away from it.
- Update: when upd_valid_i is high, the lowest set bit of upd_way_vec_i is the accessed way. An all-zero vector is ignored.
  - The tree is always updated.
  - If upd_fill_i is high, fifo_ptr is set to accessed way + 1, mod NUM_WAY.
- Policy candidate:
  - PLRU: walk the tree from the root.
  - FIFO: fifo_ptr.
  - RANDOM: lfsr[$clog2(NUM_WAY)-1:0].
- Victim priority:
  1. The lowest-index way that is invalid and unlocked.
  2. Otherwise the policy candidate, if unlocked.
  3. Otherwise the first unlocked way scanning upward from the candidate, with wrap-around.
  4. If every way is locked: vic_none_o = 1 and vic_way_o = 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Steps once per accepted request.
- FSM:
  - INIT: clears tree and fifo_ptr of one set per cycle, set 0 up to NUM_SET-1, then moves to READY.
  - READY: accepts requests and updates.
  - Reset or flush_i enters INIT; a flush in INIT restarts the sweep at set 0.
  - Updates arriving in INIT are dropped.

## Timing
- Reset values: vic_valid_o=0, vic_way_o=0, vic_none_o=0, vic_ready_o=0, busy_o=1, LFSR=LFSR_SEED, FSM in INIT.
- busy_o is high for exactly NUM_SET cycles after reset deasserts. vic_ready_o = !busy_o.
- Response latency is 1 cycle: a request accepted at edge t produces vic_valid_o, vic_way_o and vic_none_o for exactly one cycle after edge t+1. Outputs are registered.
- A new request may be accepted every cycle; there is no backpressure on the response.
- Update and request to the same set in the same cycle: the victim uses the pre-update state. The update becomes visible to a request issued in the next cycle.
- An update is written at the edge that samples it.
- flush_i in the same cycle as an accepted request: the response is still issued next cycle, computed from pre-flush state.

## Structure
- Shared package `repl_pkg`:
  - `repl_mode_e` enum: PLRU, FIFO, RANDOM.
  - LFSR polynomial constant.
  - `repl_state_t` packed struct: tree, fifo_ptr.
- Sub-module `repl_tree_pick` is combinational. It takes a tree, the valid and lock masks, and the candidate, and returns the victim one-hot plus a none flag. The controller owns the state array, the FSM and the LFSR.

## Test plan
1. Reset with NUM_SET=64 → busy_o high for 64 cycles with vic_ready_o=0; a request in cycle 65 is accepted and returns a response one cycle later.
2. PLRU, set 5, all valid, no locks. Update way0, then way2. Request → vic_way_o=4'b0010.
3. Any mode, vic_valid_vec_i=4'b1011 → vic_way_o=4'b0100. With lock_mask_i=4'b0100 as well → that way is skipped and the policy candidate is used.
4. PLRU state from scenario 2 with lock_mask_i=4'b0010 → 4'b0100. With lock_mask_i=4'b1111 → vic_none_o=1 and vic_way_o=0.
5. FIFO: fills to ways 0 and 1 of set 3 → set 3 victim 4'b0100; set 4 victim 4'b0001.
6. Update to way1 and request to set 7 in the same cycle → response is pre-update (4'b0001). flush_i mid-traffic → busy_o high for 64 cycles, and all sets read back as the reset victim way0.
